// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch stage: one outstanding 32-bit bus read, result presented with valid/ready.
// Define IFU_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt counter outputs.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_fault
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      DROP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] target;
   logic        capture;
   logic        unused_target_lsbs;

   assign target             = {redirect_pc[31:2], 2'b00};
   assign unused_target_lsbs = ^redirect_pc[1:0];

   assign mem_req_valid = (state == REQ) && !rst;
   assign mem_req_addr  = pc;
   assign out_valid     = (state == HOLD) && !rst;

   always_ff @(posedge clk) begin
      if (rst) state <= REQ;
      else     state <= state_nxt;
   end

   // DROP exists so a request accepted under a redirect still has its response swallowed.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      capture   = 1'b0;
      case (state)
         REQ: begin
            if (redirect_valid) pc_nxt = target;
            if (mem_req_ready) state_nxt = redirect_valid ? DROP : WAIT;
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_nxt    = target;
               state_nxt = mem_resp_valid ? REQ : DROP;
            end else if (mem_resp_valid) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_nxt    = target;
               state_nxt = REQ;
            end else if (out_ready) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = REQ;
            end
         end
         DROP: begin
            if (redirect_valid) pc_nxt = target;
            if (mem_resp_valid) state_nxt = REQ;
         end
         default: state_nxt = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         out_pc    <= '0;
         out_inst  <= '0;
         out_fault <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (capture) begin
            out_pc    <= pc;
            out_inst  <= mem_resp_err ? '0 : mem_resp_data;
            out_fault <= mem_resp_err;
         end
      end
   end

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (out_valid && out_ready && !redirect_valid)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if ((state == REQ && !mem_req_ready) || state == WAIT || state == DROP)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, corner-case sequences and a
// randomized run against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_fault;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(32'h3000_0000)) dut (
      .clk(clk),
      .rst(rst),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc(out_pc),
      .out_inst(out_inst),
      .out_fault(out_fault)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      out_ready      = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rq_rdy;
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        rsp_e;
      logic        o_rdy;
      logic        e_req_v;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_fault;
   } vec_t;

   function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rq_rdy,
                               input logic rsp_v, input logic [31:0] rsp_d, input logic rsp_e,
                               input logic o_rdy, input logic e_req_v, input logic [31:0] e_addr,
                               input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst,
                               input logic e_fault);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rq_rdy = rq_rdy; v.rsp_v = rsp_v; v.rsp_d = rsp_d;
      v.rsp_e = rsp_e; v.o_rdy = o_rdy; v.e_req_v = e_req_v; v.e_addr = e_addr;
      v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_fault = e_fault;
      return v;
   endfunction

   // transaction-level model state for the randomized run
   bit          m_outstanding;
   bit          m_stale;
   bit          m_held;
   logic [31:0] m_exp_pc;
   logic [31:0] m_req_addr;
   logic [31:0] m_h_pc;
   logic [31:0] m_h_inst;
   logic        m_h_fault;
   int unsigned m_delay;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[13];
      logic [31:0] tgt;
      logic        acc;

      rst = 1'b1;
      idle_inputs();

      // ---------------- directed vector table ----------------
      //            rv    rpc            rdy   rspv  rspd           err   ordy  ereq  eaddr          eov   epc            einst          efault
      vecs[0]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3000_0000, 1'b0, 32'h0,         32'h0,         1'b0);
      vecs[1]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
      vecs[2]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h3000_0000, 32'h0010_0093, 1'b0);
      vecs[3]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3000_0004, 1'b0, 32'h0,         32'h0,         1'b0);
      vecs[4]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
      vecs[5]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h3000_0004, 32'h0,         1'b1);
      vecs[6]  = mk(1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h3000_0004, 32'h0,         1'b1);
      vecs[7]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0,         32'h0,         1'b0);
      vecs[8]  = mk(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0,         32'h0,         1'b0);
      vecs[9]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,         1'b0);
      vecs[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
      vecs[11] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
      vecs[12] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0);

      do_reset();
      for (int i = 0; i < 13; i++) begin
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         mem_req_ready  = vecs[i].rq_rdy;
         mem_resp_valid = vecs[i].rsp_v;
         mem_resp_data  = vecs[i].rsp_d;
         mem_resp_err   = vecs[i].rsp_e;
         out_ready      = vecs[i].o_rdy;
         #1;
         chk($sformatf("v%0d_req_valid", i), {31'd0, mem_req_valid}, {31'd0, vecs[i].e_req_v});
         if (vecs[i].e_req_v) chk($sformatf("v%0d_req_addr", i), mem_req_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_out_inst", i), out_inst, vecs[i].e_inst);
            chk($sformatf("v%0d_out_fault", i), {31'd0, out_fault}, {31'd0, vecs[i].e_fault});
         end
         @(negedge clk);
      end
      idle_inputs();

      // ---------------- HOLD backpressure for 5 cycles ----------------
      do_reset();
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_0513;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("hold%0d_out_pc", k), out_pc, 32'h3000_0000);
         chk($sformatf("hold%0d_out_inst", k), out_inst, 32'h0000_0513);
         chk($sformatf("hold%0d_req_valid", k), {31'd0, mem_req_valid}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("hold_rel_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("hold_rel_req_addr", mem_req_addr, 32'h3000_0004);
      chk("hold_rel_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'd1);
      chk("perf_stall_cnt", perf_stall_cnt, 32'd2);
`endif

      // ---------------- redirect in WAIT, late response ----------------
      do_reset();
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0012;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("drop_wait_out_valid", {31'd0, out_valid}, 32'd0);
      chk("drop_wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1234_5678;
      #1;
      chk("drop_resp_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      chk("drop_after_out_valid", {31'd0, out_valid}, 32'd0);
      chk("drop_after_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("drop_after_req_addr", mem_req_addr, 32'h8000_0010);
      mem_req_ready = 1'b1;
      @(negedge clk);
      // redirect and response in the same WAIT cycle: discarded, straight back to REQ
      mem_req_ready  = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4000_0000;
      mem_resp_valid = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("wait_rr_out_valid", {31'd0, out_valid}, 32'd0);
      chk("wait_rr_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("wait_rr_req_addr", mem_req_addr, 32'h4000_0000);

      // ---------------- reset mid-transaction ----------------
      do_reset();
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst            = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hCAFE_F00D;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("mid_rst_req_addr", mem_req_addr, 32'h3000_0000);

      // ---------------- randomized run against transaction model ----------------
      do_reset();
      m_outstanding = 1'b0;
      m_stale       = 1'b0;
      m_held        = 1'b0;
      m_exp_pc      = 32'h3000_0000;
      m_req_addr    = '0;
      m_h_pc        = '0;
      m_h_inst      = '0;
      m_h_fault     = 1'b0;
      m_delay       = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         #1;
         chk("rnd_req_valid", {31'd0, mem_req_valid}, {31'd0, !m_outstanding && !m_held});
         if (!m_outstanding && !m_held) chk("rnd_req_addr", mem_req_addr, m_exp_pc);
         chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_held});
         if (m_held) begin
            chk("rnd_out_pc", out_pc, m_h_pc);
            chk("rnd_out_inst", out_inst, m_h_inst);
            chk("rnd_out_fault", {31'd0, out_fault}, {31'd0, m_h_fault});
         end

         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | {28'd0, 4'($urandom())})
                                                      : $urandom();
         mem_req_ready  = ($urandom_range(0, 2) != 0);
         out_ready      = ($urandom_range(0, 3) != 0);
         mem_resp_data  = $urandom();
         mem_resp_err   = ($urandom_range(0, 7) == 0);
         mem_resp_valid = 1'b0;
         if (m_outstanding) begin
            if (m_delay == 0) mem_resp_valid = 1'b1;
            else m_delay--;
         end

         tgt = {redirect_pc[31:2], 2'b00};
         acc = !m_outstanding && !m_held && mem_req_ready;
         if (m_held) begin
            if (redirect_valid) begin
               m_held   = 1'b0;
               m_exp_pc = tgt;
            end else if (out_ready) begin
               m_held   = 1'b0;
               m_exp_pc = m_exp_pc + 32'd4;
            end
         end else if (m_outstanding) begin
            if (redirect_valid) begin
               m_stale  = 1'b1;
               m_exp_pc = tgt;
            end
            if (mem_resp_valid) begin
               m_outstanding = 1'b0;
               if (!m_stale) begin
                  m_held    = 1'b1;
                  m_h_pc    = m_req_addr;
                  m_h_inst  = mem_resp_err ? 32'd0 : mem_resp_data;
                  m_h_fault = mem_resp_err;
               end
            end
         end else begin
            if (acc) begin
               m_outstanding = 1'b1;
               m_stale       = redirect_valid;
               m_req_addr    = m_exp_pc;
               m_delay       = $urandom_range(0, 3);
            end
            if (redirect_valid) m_exp_pc = tgt;
         end
         @(negedge clk);
      end
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
